// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS register file slice.
package mips_pkg;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef logic [AW-1:0] reg_addr_t;

endpackage : mips_pkg

// File: rtl/mips_sb_pending.sv
// Pending-write scoreboard: one bit per register, set at issue and cleared at
// write-back. Also provides the busy lookup for the two read ports.
module mips_sb_pending
    import mips_pkg::*;
#(
    parameter int AW     = mips_pkg::AW,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_wa,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic          flush,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          busy1,
    output logic          busy2
);

    localparam int NREG = 2 ** AW;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_next;
    logic            w_set;
    logic            w_clr;
    logic            w_sat1;
    logic            w_sat2;

    assign w_set = issue_valid && (issue_wa != ZERO_ADDR);
    assign w_clr = we && (wa != ZERO_ADDR);

    // Apply flush, then clear, then set, so a new issue always wins over both.
    always_comb begin
        w_pending_next = flush ? '0 : r_pending;
        if (w_clr) begin
            w_pending_next[wa] = 1'b0;
        end
        if (w_set) begin
            w_pending_next[issue_wa] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    assign w_sat1 = (BYPASS != 0) && we && (wa == ra1);
    assign w_sat2 = (BYPASS != 0) && we && (wa == ra2);

    assign busy1 = r_pending[ra1] && !w_sat1;
    assign busy2 = r_pending[ra2] && !w_sat2;

endmodule : mips_sb_pending

// File: rtl/mips_regfile_sb.sv
// 32x32 MIPS register file with two combinational read ports, one write port,
// optional write-to-read forwarding and a pending-write scoreboard.
module mips_regfile_sb
    import mips_pkg::*;
#(
    parameter int DW     = mips_pkg::DW,
    parameter int AW     = mips_pkg::AW,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_wa,
    input  logic          flush,
    output logic          busy1,
    output logic          busy2
);

    localparam int NREG = 2 ** AW;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [DW-1:0] r_regs [NREG];
    logic          w_wr;
    logic          w_byp1;
    logic          w_byp2;

    assign w_wr = we && (wa != ZERO_ADDR);

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[wa] <= wd;
        end
    end

    assign w_byp1 = (BYPASS != 0) && w_wr && (wa == ra1);
    assign w_byp2 = (BYPASS != 0) && w_wr && (wa == ra2);

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != ZERO_ADDR) begin
            rd1 = w_byp1 ? wd : r_regs[ra1];
        end
        if (ra2 != ZERO_ADDR) begin
            rd2 = w_byp2 ? wd : r_regs[ra2];
        end
    end

    mips_sb_pending #(
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_pending (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_wa    (issue_wa),
        .we          (we),
        .wa          (wa),
        .flush       (flush),
        .ra1         (ra1),
        .ra2         (ra2),
        .busy1       (busy1),
        .busy2       (busy2)
    );

endmodule : mips_regfile_sb

// File: tb/tb_mips_regfile_sb.sv
// Directed plus randomized bench for mips_regfile_sb against an array-based
// model of the register contents and the pending marks.
module tb_mips_regfile_sb;
    import mips_pkg::*;

    localparam int BYPASS = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] ra1 = '0;
    logic [AW-1:0] ra2 = '0;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          we = 1'b0;
    logic [AW-1:0] wa = '0;
    logic [DW-1:0] wd = '0;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_wa = '0;
    logic          flush = 1'b0;
    logic          busy1;
    logic          busy2;

    logic [DW-1:0] mRegs [32];
    bit   [31:0]   mPend;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    mips_regfile_sb #(
        .DW     (DW),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ra1         (ra1),
        .ra2         (ra2),
        .rd1         (rd1),
        .rd2         (rd2),
        .we          (we),
        .wa          (wa),
        .wd          (wd),
        .issue_valid (issue_valid),
        .issue_wa    (issue_wa),
        .flush       (flush),
        .busy1       (busy1),
        .busy2       (busy2)
    );

    function automatic logic [DW-1:0] expRead(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (BYPASS != 0 && we && wa == a) return wd;
        return mRegs[a];
    endfunction

    function automatic logic expBusy(input logic [AW-1:0] a);
        return mPend[a] && !(BYPASS != 0 && we && wa == a);
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        mPend = '0;
    endtask

    task automatic checkOutput(input string tag);
        logic [DW-1:0] e1, e2;
        logic          b1, b2;
        e1 = expRead(ra1);
        e2 = expRead(ra2);
        b1 = expBusy(ra1);
        b2 = expBusy(ra2);
        checks++;
        assert (rd1 === e1) else begin
            failures++;
            $error("[TB] FAIL %s rd1 observed=%h expected=%h", tag, rd1, e1);
        end
        checks++;
        assert (rd2 === e2) else begin
            failures++;
            $error("[TB] FAIL %s rd2 observed=%h expected=%h", tag, rd2, e2);
        end
        checks++;
        assert (busy1 === b1) else begin
            failures++;
            $error("[TB] FAIL %s busy1 observed=%b expected=%b", tag, busy1, b1);
        end
        checks++;
        assert (busy2 === b2) else begin
            failures++;
            $error("[TB] FAIL %s busy2 observed=%b expected=%b", tag, busy2, b2);
        end
    endtask

    // Called one time unit after a rising edge: drive, check, clock, update model.
    task automatic applyStimulus(
        input logic [AW-1:0] a1, input logic [AW-1:0] a2,
        input logic w, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
        input logic iv, input logic [AW-1:0] iwa, input logic fl,
        input string tag
    );
        ra1 = a1; ra2 = a2;
        we = w; wa = waddr; wd = wdata;
        issue_valid = iv; issue_wa = iwa; flush = fl;
        #1;
        checkOutput(tag);
        @(posedge clk);
        if (w && waddr != 0) mRegs[waddr] = wdata;
        if (fl) mPend = '0;
        if (w && waddr != 0) mPend[waddr] = 1'b0;
        if (iv && iwa != 0) mPend[iwa] = 1'b1;
        #1;
    endtask

    function automatic logic [AW-1:0] randAddr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, 31));
    endfunction

    initial begin
        clearModel();
        $display("[TB] reset and directed sequence");
        rst_n = 1'b0;
        ra1 = 5'd5; ra2 = 5'd31;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state");
        rst_n = 1'b1;

        applyStimulus(5'd8, 5'd0, 1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, "write8_bypass");
        applyStimulus(5'd8, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, "read8");
        applyStimulus(5'd8, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 1'b0, "write0");
        applyStimulus(5'd8, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, "read0");

        applyStimulus(5'd9, 5'd9, 1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 1'b0, "bypass_both");

        applyStimulus(5'd10, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0, "issue10");
        applyStimulus(5'd10, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, "busy10");
        applyStimulus(5'd10, 5'd0, 1'b1, 5'd10, 32'hA5, 1'b0, 5'd0, 1'b0, "wb10_satisfies");
        applyStimulus(5'd10, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, "cleared10");

        applyStimulus(5'd12, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0, "issue12");
        applyStimulus(5'd12, 5'd0, 1'b1, 5'd12, 32'hC0, 1'b1, 5'd12, 1'b0, "set_wins12");
        applyStimulus(5'd12, 5'd13, 1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 1'b1, "flush_issue13");
        applyStimulus(5'd12, 5'd13, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, "after_flush");

        applyStimulus(5'd3, 5'd4, 1'b1, 5'd3, 32'h55, 1'b1, 5'd4, 1'b0, "load3_issue4");
        ra1 = 5'd3; ra2 = 5'd4;
        we = 1'b0; wa = '0; wd = '0;
        issue_valid = 1'b0; issue_wa = '0; flush = 1'b0;
        #1;
        checkOutput("pre_async_reset");
        #2;
        rst_n = 1'b0;
        clearModel();
        #1;
        checkOutput("async_reset");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] randomized sequence");
        for (int n = 0; n < 600; n++) begin
            applyStimulus(randAddr(), randAddr(),
                          ($urandom_range(0, 2) == 0), randAddr(), $urandom(),
                          ($urandom_range(0, 1) == 0), randAddr(),
                          ($urandom_range(0, 29) == 0), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mips_regfile_sb

// File: doc/mips_regfile_sb.md
Name: mips_regfile_sb

Overview:
- 32x32 MIPS general-purpose register file with 2 combinational read ports and 1 synchronous write port.
- Includes a pending-write scoreboard.
- The 5-bit destination address from the RegDst select (rt/rd) feeds issue_wa, which marks a register as pending. The write-back stage clears it via wa/we.
- Decode reads operands here; busy1/busy2 drive the hazard/stall logic.

Parameters:
- DW, 32, data width of each register.
- AW, 5, register address width (2**AW registers).
- BYPASS, 1, 1 = write-to-read forwarding in the same cycle; 0 = read returns the old value.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ra1  in  AW  read address, port 1 (rs).
- ra2  in  AW  read address, port 2 (rt).
- rd1  out  DW  read data, port 1.
- rd2  out  DW  read data, port 2.
- we  in  1  write-back enable.
- wa  in  AW  write-back address.
- wd  in  DW  write-back data.
- issue_valid  in  1  an instruction with a register destination issues this cycle.
- issue_wa  in  AW  destination of the issuing instruction (RegDst mux output).
- flush  in  1  discard all pending marks (pipeline flush).
- busy1  out  1  ra1 has an outstanding write that is not satisfied this cycle.
- busy2  out  1  ra2 has an outstanding write that is not satisfied this cycle.

Behaviour:
- Reset: rst_n low clears all 32 registers and the pending vector to 0, asynchronously. rd1/rd2 then read 0 and busy1/busy2 are 0.
- Register 0:
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0.
  - issue_wa==0 never sets pending[0], so busy for address 0 is always 0.
- Write: on the rising clk edge, if we && wa!=0, then reg[wa] <= wd. Write latency is 1 cycle.
- Read: rdN = reg[raN], combinational with zero latency.
- Bypass (BYPASS=1): if we && wa!=0 && wa==raN, then rdN = wd in the same cycle. Both ports may bypass at once.
- Scoreboard, pending[31:0], updated on the clk edge:
  - set = issue_valid && issue_wa!=0 sets bit issue_wa.
  - clr = we && wa!=0 clears bit wa.
  - Set and clear of the same index in the same cycle: set wins and the bit stays 1. This covers back-to-back writers in the in-order pipeline.
  - Set and clear of different indices apply independently.
  - flush clears every bit. A simultaneous issue_valid still sets its bit, because the issuing instruction is post-flush.
- Busy:
  - BYPASS=1: busyN = pending[raN] && !(we && wa==raN). A same-cycle write-back satisfies the read.
  - BYPASS=0: busyN = pending[raN].
- Only one outstanding writer per register is tracked. The hazard unit stalls issue when busy covers the destination (WAW), so no counter is needed.
- Reset asserted mid-operation clears everything immediately. A write in flight at the reset edge is lost.
- No X propagation: every read index is in range because there are exactly 2**AW registers.

Decomposition:
- Shared package mips_pkg holds: DW, AW, REG_ZERO=5'd0, REG_RA=5'd31 constants, and a reg_addr_t typedef (AW bits).
- One natural sub-module is mips_sb_pending, holding the pending vector plus set/clear/flush logic and the busy lookup.
- Storage and bypass stay in the top level.

Test Plan:
1. Reset then read: deassert rst_n after 2 cycles, read ra1=5, ra2=31 -> rd1=0, rd2=0, busy1=busy2=0.
2. Write/read: we=1, wa=8, wd=32'hDEADBEEF for 1 cycle, then ra1=8 -> rd1=32'hDEADBEEF. Next, we=1, wa=0, wd=32'h1234, then ra2=0 -> rd2=0.
3. Bypass: at the cycle where we=1, wa=9, wd=32'h00000077, set ra1=ra2=9 -> rd1=rd2=32'h77 in the same cycle. With BYPASS=0 -> old value 0.
4. Scoreboard:
   - issue_valid=1, issue_wa=10; next cycle ra1=10 -> busy1=1.
   - Write-back we=1, wa=10 that cycle -> busy1=0 combinationally, pending[10]=0 after the edge.
5. Simultaneous events:
   - issue_wa=12 with we=1, wa=12 in the same cycle -> pending[12] stays 1.
   - flush=1 with issue_wa=13 -> only pending[13]=1 afterwards.
6. Async reset mid-run: load r3=32'h55, pending[4]=1; pull rst_n low between edges -> r3 reads 0 and busy on ra=4 drops immediately, with no clk edge needed.
